// File: rtl/cmd_src_arb.sv
// Arbitrates cmd_proc between the UART remote path and the tour sequencer.
// Grants one source at a time (round-robin on ties), routes completion back to the owner.
//
//   state | meaning
//   IDLE  | no command outstanding, evaluating requests
//   ISSUE | cmd offered to cmd_proc, waiting for clr_cmd_rdy
//   BUSY  | cmd_proc executing, watchdog running
module cmd_src_arb #(
    parameter int TMO_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] rmt_cmd,
    input  logic        rmt_cmd_rdy,
    output logic        clr_rmt_rdy,
    input  logic [15:0] tour_cmd,
    input  logic        tour_cmd_rdy,
    output logic        clr_tour_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic        resp_rmt,
    output logic        resp_tour,
    output logic        tmo,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    localparam logic [TMO_W-1:0] WD_MAX  = '1;
    localparam logic [TMO_W-1:0] WD_TRIP = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] WD_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [TMO_W-1:0]   wdog_q, wdog_d;
    logic [15:0]        cmd_d;
    logic               cmd_rdy_d, busy_d;
    logic               clr_rmt_d, clr_tour_d;
    logic               resp_rmt_d, resp_tour_d, tmo_d;
    logic               grant_rmt, grant_tour, wdog_trip;

    // last_q=1 means tour was granted last, so remote wins a tie
    assign grant_rmt  = rmt_cmd_rdy && (!tour_cmd_rdy || last_q);
    assign grant_tour = tour_cmd_rdy && !grant_rmt;
    // the increment taking the counter to all-ones is the expiry event
    assign wdog_trip  = (wdog_q == WD_TRIP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_rmt || grant_tour) state_d = ISSUE;
            ISSUE:   if (clr_cmd_rdy) state_d = BUSY;
            BUSY:    if (send_resp || wdog_trip) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_d       = cmd;
        owner_d     = owner_q;
        last_d      = last_q;
        wdog_d      = wdog_q;
        clr_rmt_d   = 1'b0;
        clr_tour_d  = 1'b0;
        resp_rmt_d  = 1'b0;
        resp_tour_d = 1'b0;
        tmo_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_rmt) begin
                    cmd_d     = rmt_cmd;
                    owner_d   = 1'b0;
                    last_d    = 1'b0;
                    clr_rmt_d = 1'b1;
                end else if (grant_tour) begin
                    cmd_d      = tour_cmd;
                    owner_d    = 1'b1;
                    last_d     = 1'b1;
                    clr_tour_d = 1'b1;
                end
            end
            ISSUE: begin
                if (clr_cmd_rdy) wdog_d = '0;
            end
            BUSY: begin
                if (wdog_q != WD_MAX) wdog_d = wdog_q + WD_ONE;
                if (send_resp) begin
                    resp_rmt_d  = !owner_q;
                    resp_tour_d = owner_q;
                end else if (wdog_trip) begin
                    tmo_d = 1'b1;
                end
            end
            default: ;
        endcase
        cmd_rdy_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd          <= 16'h0000;
            cmd_rdy      <= 1'b0;
            busy         <= 1'b0;
            clr_rmt_rdy  <= 1'b0;
            clr_tour_rdy <= 1'b0;
            resp_rmt     <= 1'b0;
            resp_tour    <= 1'b0;
            tmo          <= 1'b0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            wdog_q       <= '0;
        end else begin
            cmd          <= cmd_d;
            cmd_rdy      <= cmd_rdy_d;
            busy         <= busy_d;
            clr_rmt_rdy  <= clr_rmt_d;
            clr_tour_rdy <= clr_tour_d;
            resp_rmt     <= resp_rmt_d;
            resp_tour    <= resp_tour_d;
            tmo          <= tmo_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            wdog_q       <= wdog_d;
        end
    end

endmodule

// File: doc/cmd_src_arb.md
# cmd_src_arb

Arbitrates the single command processor (`cmd_proc`) in `KnightsTour` between two 16-bit command sources: the UART remote path and the on-chip tour sequencer. It sits between `UART_wrapper`/`TourCmd` and `cmd_proc`. It grants one source at a time, round-robin on ties, and holds that grant until `cmd_proc` signals completion. It then routes the completion back to the owning source, so only remote-originated commands produce an `8'hA5` response on the UART. A watchdog frees the resource if a command never completes.

## Interface
- `TMO_W`, 26: width of the watchdog counter. A timeout fires after 2^TMO_W−1 cycles in BUSY, about 1.34 s at 50 MHz.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `rmt_cmd`  in  16  command from the UART wrapper
- `rmt_cmd_rdy`  in  1  remote command valid; level, held until cleared
- `clr_rmt_rdy`  out  1  one-cycle pulse that consumes `rmt_cmd`
- `tour_cmd`  in  16  command from the tour sequencer
- `tour_cmd_rdy`  in  1  tour command valid; level, held until cleared
- `clr_tour_rdy`  out  1  one-cycle pulse that consumes `tour_cmd`
- `cmd`  out  16  granted command to `cmd_proc`
- `cmd_rdy`  out  1  `cmd` valid for `cmd_proc`
- `clr_cmd_rdy`  in  1  `cmd_proc` has accepted `cmd`
- `send_resp`  in  1  `cmd_proc` has finished the command
- `resp_rmt`  out  1  one-cycle pulse: remote command done; drives the UART to transmit `8'hA5`
- `resp_tour`  out  1  one-cycle pulse: tour step done
- `tmo`  out  1  one-cycle pulse: watchdog expired
- `busy`  out  1  high in ISSUE and BUSY

## Operation
- States: IDLE, ISSUE, BUSY.
- Internal `owner` bit (0=remote, 1=tour) records the current grant. `last` bit records the previous grant for round-robin.
- IDLE:
  - Grant remote if `rmt_cmd_rdy` and (not `tour_cmd_rdy` or `last`=tour).
  - Otherwise grant tour if `tour_cmd_rdy`.
  - On a grant:
    - latch the source command into `cmd`;
    - set `owner` and `last`;
    - pulse the matching `clr_*_rdy`;
    - go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - `cmd_rdy`=1.
  - On `clr_cmd_rdy`: go to BUSY, clear the watchdog, drop `cmd_rdy`.
  - ISSUE has no timeout; it waits indefinitely.
- BUSY:
  - The watchdog increments every cycle.
  - On `send_resp`: pulse `resp_rmt` if owner=remote, else `resp_tour`; go to IDLE.
  - When the watchdog reaches all-ones without `send_resp`: pulse `tmo`, emit no resp pulse, go to IDLE.
- `cmd` holds its value until the next grant. It is not cleared on completion.
- `send_resp` in IDLE or ISSUE is ignored. `clr_cmd_rdy` outside ISSUE is ignored.
- Requests arriving while ISSUE or BUSY stay pending. They are evaluated on return to IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd`=16'h0000, `cmd_rdy`=0, `busy`=0;
  - `clr_rmt_rdy`, `clr_tour_rdy`, `resp_rmt`, `resp_tour`, `tmo` all 0;
  - state IDLE, watchdog 0, `owner`=remote, `last`=tour, so remote wins the first tie.
- Grant latency:
  - A request sampled at edge N in IDLE gives `cmd`, `cmd_rdy`=1, `busy`=1 and the `clr_*_rdy` pulse during cycle N+1.
  - The source's `rdy` must drop by edge N+2. Because the arbiter is no longer in IDLE, a late drop cannot cause a double grant.
- `clr_cmd_rdy` sampled at edge M puts `cmd_rdy`=0 in cycle M+1.
- `send_resp` sampled at edge K gives the resp pulse and `busy`=0 in cycle K+1. The next grant is possible at edge K+1, with outputs in cycle K+2.
- `send_resp` arriving in the same cycle the watchdog hits all-ones: completion wins, so the resp pulse fires and `tmo` does not.
- Watchdog width is `TMO_W`. The counter saturates and never wraps.
- Asserting `rst_n` mid-command:
  - the machine returns to IDLE immediately and all outputs go to reset values;
  - the pending source `rdy` flags are not cleared by this block.

## Test plan
- Reset, then hold `rmt_cmd_rdy`=1 with `rmt_cmd`=16'h0000 (calibrate) → one cycle later `cmd`=16'h0000, `cmd_rdy`=1, one-cycle `clr_rmt_rdy`. After `clr_cmd_rdy` then `send_resp`, exactly one `resp_rmt` pulse and no `resp_tour`.
- Assert `rmt_cmd_rdy` and `tour_cmd_rdy` together three times in a row → grants go remote, tour, remote. Each `cmd` equals the granted source's command, and each source sees exactly one `clr` pulse per grant.
- Tour owns the grant (`tour_cmd`=16'h4BF2) and `rmt_cmd_rdy` rises during BUSY → `cmd` stays 16'h4BF2, no `clr_rmt_rdy` until after the `resp_tour` pulse, then remote is granted 2 cycles after `send_resp`.
- `TMO_W`=4, grant, then `clr_cmd_rdy` and no `send_resp` → `tmo` pulses 15 cycles into BUSY, followed by IDLE, `busy`=0, and no resp pulse. Repeat with `send_resp` on the expiry cycle → `resp_*` pulses and `tmo` stays 0.
- Assert `rst_n` low while in BUSY with owner=tour → all outputs 0 asynchronously. After release, a pending `rmt_cmd_rdy` is granted first.
- Pulse `send_resp` and `clr_cmd_rdy` while IDLE with no requests → no output changes and state stays IDLE.
